tensor_core_controller: RTL and testbench

Tensor-core-side receiver for the 16-bit instruction stream driven by the memory controller. It decodes NOP, OPERATE, BURST and RESET words and holds the A/B operand matrices and the C result matrix. It runs a sequential MATRIX_DIM×MATRIX_DIM matrix multiply and returns result bytes on `tensor_core_controller_output` during burst-read slots. The controller never stalls the instruction stream: the stream is fixed-schedule, and the block reports misuse through `error_out`.

---
 rtl/tensor_core_pkg.sv | 38 +++
 rtl/tensor_core_mac_unit.sv | 61 ++++++
 rtl/tensor_core_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_tensor_core_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor-core instruction receiver: opcodes, burst selects, FSM states, header field slices.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tensor_core_pkg;

    // Opcode field [1:0]
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_OPERATE = 2'b01;
    localparam logic [1:0] OP_BURST   = 2'b10;
    localparam logic [1:0] OP_RESET   = 2'b11;

    // Burst select field [3:2]
    localparam logic [1:0] BSEL_READ    = 2'b00;
    localparam logic [1:0] BSEL_WRITE   = 2'b01;
    localparam logic [1:0] BSEL_RDWR    = 2'b10;
    localparam logic [1:0] BSEL_ILLEGAL = 2'b11;

    // Header field positions
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 1;
    localparam int BSEL_LSB = 2;
    localparam int BSEL_MSB = 3;
    localparam int LEN_LSB  = 4;
    localparam int LEN_MSB  = 7;

    // Burst write data word positions: A element in the upper byte, B in the lower
    localparam int WA_LSB = 8;
    localparam int WA_MSB = 15;
    localparam int WB_LSB = 0;
    localparam int WB_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_COMPUTE = 2'd2
    } state_t;

endpackage

// File: rtl/tensor_core_mac_unit.sv
// Signed multiply-accumulate with reduction of (acc + product) to DATA_WIDTH for C writes.
// Latency: result is combinational from the current operands and registered accumulator; acc updates at the next edge.
// Backpressure: none; driven one MAC per cycle by the controller. Optional macro: TENSOR_CORE_SATURATE_EN.
//
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_clr            clear the accumulator (wins over i_acc_en)
//   i_acc_en         acc <= acc + i_a*i_b
//   i_a, i_b         signed operands
//   o_result         (acc + i_a*i_b) reduced to DATA_WIDTH: clamped with TENSOR_CORE_SATURATE_EN, wrapped otherwise
module tensor_core_mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_acc_en,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_result
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_prod = i_a * i_b;
    assign w_sum  = r_acc + {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= w_sum;
        end
    end

`ifdef TENSOR_CORE_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN = -ACC_WIDTH'(2 ** (DATA_WIDTH-1));
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        o_result = w_sum[DATA_WIDTH-1:0];
        if (w_sum > SAT_MAX) begin
            o_result = OUT_MAX;
        end else if (w_sum < SAT_MIN) begin
            o_result = OUT_MIN;
        end
    end
`else
    assign o_result = w_sum[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/tensor_core_controller.sv
// Tensor-core receiver: decodes the 16-bit instruction stream, holds A/B/C, runs a sequential NxN matmul, serves burst reads.
// Latency: burst-read data is combinational in the slot cycle; OPERATE takes N^3 cycles, done pulses the cycle after the last C write.
// Backpressure: none; the stream is fixed-schedule, misuse sets sticky error_out. Optional macro: TENSOR_CORE_SATURATE_EN (C writes clamp).
//
// Ports:
//   clock_in                         rising-edge clock
//   reset_in                         asynchronous active-low reset
//   current_tensor_core_instruction  header or burst data word, one per cycle
//   tensor_core_controller_output    C[idx] during burst-read slots, 0 otherwise
//   busy_out                         high while computing
//   operation_done_out               one-cycle pulse after the final C write
//   error_out                        sticky protocol error, cleared by reset_in or the RESET opcode
module tensor_core_controller
    import tensor_core_pkg::*;
#(
    parameter int MATRIX_DIM = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [15:0]                  current_tensor_core_instruction,
    output logic signed [DATA_WIDTH-1:0] tensor_core_controller_output,
    output logic                         busy_out,
    output logic                         operation_done_out,
    output logic                         error_out
);

    localparam int ELEMS = MATRIX_DIM * MATRIX_DIM;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int CNT_W = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(MATRIX_DIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MATRIX_DIM - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_WIDTH-1:0] r_a [ELEMS];
    logic signed [DATA_WIDTH-1:0] r_b [ELEMS];
    logic signed [DATA_WIDTH-1:0] r_c [ELEMS];

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last_idx;
    logic [1:0]       r_bsel;
    logic [CNT_W-1:0] r_i, r_j, r_k;
    logic             r_busy, r_done, r_err;

    // Header decode
    logic [1:0] w_opc;
    logic [1:0] w_bsel;
    logic [3:0] w_len;
    logic [DATA_WIDTH-1:0] w_word_a;
    logic [DATA_WIDTH-1:0] w_word_b;
    logic       w_burst_legal;

    assign w_opc    = current_tensor_core_instruction[OPC_MSB:OPC_LSB];
    assign w_bsel   = current_tensor_core_instruction[BSEL_MSB:BSEL_LSB];
    assign w_len    = current_tensor_core_instruction[LEN_MSB:LEN_LSB];
    assign w_word_a = current_tensor_core_instruction[WA_MSB:WA_LSB];
    assign w_word_b = current_tensor_core_instruction[WB_MSB:WB_LSB];

    assign w_burst_legal = (w_bsel != BSEL_ILLEGAL) && (w_len != 4'd0) && (int'(w_len) <= ELEMS);

    // Burst slot qualifiers (only meaningful while in BURST)
    logic w_in_burst, w_slot_rd, w_slot_wr, w_slot_last;
    assign w_in_burst  = (r_state == ST_BURST);
    assign w_slot_rd   = w_in_burst && ((r_bsel == BSEL_READ) || (r_bsel == BSEL_RDWR));
    assign w_slot_wr   = w_in_burst && ((r_bsel == BSEL_WRITE) || (r_bsel == BSEL_RDWR));
    assign w_slot_last = (r_idx == r_last_idx);

    // Loop position; k is innermost
    logic w_k_last, w_mac_last;
    assign w_k_last   = (r_k == CNT_LAST);
    assign w_mac_last = (r_i == CNT_LAST) && (r_j == CNT_LAST) && w_k_last;

    logic [IDX_W-1:0] w_a_addr, w_b_addr, w_c_addr;
    assign w_a_addr = IDX_W'(int'(r_i) * MATRIX_DIM + int'(r_k));
    assign w_b_addr = IDX_W'(int'(r_k) * MATRIX_DIM + int'(r_j));
    assign w_c_addr = IDX_W'(int'(r_i) * MATRIX_DIM + int'(r_j));

    // FSM control strobes
    logic w_start_burst, w_start_op, w_wipe, w_err_set, w_mac_step, w_done_nxt;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_burst = 1'b0;
        w_start_op    = 1'b0;
        w_wipe        = 1'b0;
        w_err_set     = 1'b0;
        w_mac_step    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (w_opc)
                    OP_NOP: ;
                    OP_OPERATE: begin
                        w_state_nxt = ST_COMPUTE;
                        w_start_op  = 1'b1;
                    end
                    OP_BURST: begin
                        if (w_burst_legal) begin
                            w_state_nxt   = ST_BURST;
                            w_start_burst = 1'b1;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end
                    default: w_wipe = 1'b1;   // OP_RESET
                endcase
            end
            ST_BURST: begin
                // Slot words are data, never opcodes
                if (w_slot_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (w_opc == OP_RESET) begin
                    // Abort: no MAC this cycle and no done pulse
                    w_wipe      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mac_step = 1'b1;
                    if ((w_opc == OP_OPERATE) || (w_opc == OP_BURST)) begin
                        w_err_set = 1'b1;
                    end
                    if (w_mac_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // MAC datapath: the k==N-1 step writes C from acc+product and restarts the accumulator
    logic                         w_mac_clr;
    logic signed [DATA_WIDTH-1:0] w_mac_result;
    assign w_mac_clr = w_start_op || w_wipe || (w_mac_step && w_k_last);

    tensor_core_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .i_clk    (clock_in),
        .i_rst_n  (reset_in),
        .i_clr    (w_mac_clr),
        .i_acc_en (w_mac_step),
        .i_a      (r_a[w_a_addr]),
        .i_b      (r_b[w_b_addr]),
        .o_result (w_mac_result)
    );

    // Register files
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int e = 0; e < ELEMS; e++) begin
                r_a[e] <= '0;
                r_b[e] <= '0;
                r_c[e] <= '0;
            end
        end else if (w_wipe) begin
            for (int e = 0; e < ELEMS; e++) begin
                r_a[e] <= '0;
                r_b[e] <= '0;
                r_c[e] <= '0;
            end
        end else begin
            if (w_slot_wr) begin
                r_a[r_idx] <= w_word_a;
                r_b[r_idx] <= w_word_b;
            end
            if (w_mac_step && w_k_last) begin
                r_c[w_c_addr] <= w_mac_result;
            end
        end
    end

    // Burst index and matmul loop counters
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_idx      <= '0;
            r_last_idx <= '0;
            r_bsel     <= BSEL_READ;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
        end else begin
            if (w_start_burst) begin
                r_idx      <= '0;
                r_last_idx <= IDX_W'(int'(w_len) - 1);
                r_bsel     <= w_bsel;
            end else if (w_in_burst) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_start_op || w_wipe) begin
                r_i <= '0;
                r_j <= '0;
                r_k <= '0;
            end else if (w_mac_step) begin
                if (w_k_last) begin
                    r_k <= '0;
                    if (r_j == CNT_LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == CNT_LAST) ? '0 : r_i + CNT_W'(1);
                    end else begin
                        r_j <= r_j + CNT_W'(1);
                    end
                end else begin
                    r_k <= r_k + CNT_W'(1);
                end
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_COMPUTE);
            r_done <= w_done_nxt;
            if (w_wipe) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read slots see C before any same-slot write; writes only touch A/B anyway
    assign tensor_core_controller_output = w_slot_rd ? r_c[r_idx] : '0;
    assign busy_out           = r_busy;
    assign operation_done_out = r_done;
    assign error_out          = r_err;

endmodule

// File: tb/tb_tensor_core_controller.sv
module tb_tensor_core_controller;
    import tensor_core_pkg::*;

    logic              clock_in = 1'b0;
    logic              reset_in = 1'b0;
    logic [15:0]       instr    = 16'h0000;
    logic signed [7:0] dout;
    logic              busy, done, err;

    tensor_core_controller #(
        .MATRIX_DIM (3),
        .DATA_WIDTH (8)
    ) dut (
        .clock_in                        (clock_in),
        .reset_in                        (reset_in),
        .current_tensor_core_instruction (instr),
        .tensor_core_controller_output   (dout),
        .busy_out                        (busy),
        .operation_done_out              (done),
        .error_out                       (err)
    );

    always #5 clock_in = ~clock_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected read-slot bytes, pushed by the driver, popped by the monitor
    logic signed [7:0] exp_q[$];
    logic              slot_rd = 1'b0;

    logic [7:0]        wa [9];
    logic [7:0]        wb [9];
    logic signed [7:0] exp_c [9];

    localparam logic [15:0] W_NOP     = {14'h0, OP_NOP};
    localparam logic [15:0] W_OPERATE = {14'h0, OP_OPERATE};
    localparam logic [15:0] W_RESET   = {14'h0, OP_RESET};

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clock_in) begin
        if (slot_rd) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_underflow: read slot with no expected value (t=%0t)", $time);
            end else begin
                check("rd_slot", int'(dout), int'(exp_q.pop_front()));
            end
        end else begin
            check("out_zero", int'(dout), 0);
        end
    end

    function automatic logic [15:0] hdr(input logic [1:0] op, input logic [1:0] sel, input logic [3:0] len);
        return {8'h00, len, sel, op};
    endfunction

    task automatic send(input logic [15:0] w, input logic rd);
        @(posedge clock_in);
        #1;
        instr   = w;
        slot_rd = rd;
    endtask

    task automatic burst_write_all();
        send(hdr(OP_BURST, BSEL_WRITE, 4'd9), 1'b0);
        for (int e = 0; e < 9; e++) send({wa[e], wb[e]}, 1'b0);
        send(W_NOP, 1'b0);
    endtask

    task automatic burst_read_all();
        send(hdr(OP_BURST, BSEL_READ, 4'd9), 1'b0);
        for (int e = 0; e < 9; e++) begin
            exp_q.push_back(exp_c[e]);
            send(16'h0000, 1'b1);
        end
        send(W_NOP, 1'b0);
    endtask

    // Issue OPERATE, then 40 bounded cycles; inject_word replaces the NOP at loop cycle inject_at
    task automatic run_operate(input int inject_at, input logic [15:0] inject_word,
                               output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        send(W_OPERATE, 1'b0);
        for (int c = 0; c < 40; c++) begin
            send((c == inject_at) ? inject_word : W_NOP, 1'b0);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
        end
    endtask

    task automatic load_identity_b();
        for (int e = 0; e < 9; e++) begin
            wa[e] = ((e % 4) == 0) ? 8'd1 : 8'd0;
            wb[e] = 8'(e + 1);
        end
    endtask

    task automatic expect_seq();
        for (int e = 0; e < 9; e++) exp_c[e] = 8'(e + 1);
    endtask

    task automatic expect_zero();
        for (int e = 0; e < 9; e++) exp_c[e] = 8'sd0;
    endtask

    int bc, dc, da;
    logic [15:0] bad_hdr [3];

    initial begin
        // Reset state
        repeat (3) @(posedge clock_in);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        reset_in = 1'b1;

        // Async reset in the middle of COMPUTE, with error_out set first
        load_identity_b();
        burst_write_all();
        send(W_OPERATE, 1'b0);
        repeat (4) send(W_NOP, 1'b0);
        send(hdr(OP_BURST, BSEL_READ, 4'd1), 1'b0);
        send(W_NOP, 1'b0);
        check("mid_busy", int'(busy), 1);
        check("mid_err", int'(err), 1);
        #2;
        reset_in = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_err", int'(err), 0);
        check("arst_out", int'(dout), 0);
        repeat (2) @(posedge clock_in);
        #1;
        reset_in = 1'b1;
        expect_zero();
        burst_read_all();

        // Identity x (1..9)
        load_identity_b();
        burst_write_all();
        run_operate(-1, W_NOP, bc, dc, da);
        check("id_busy_cycles", bc, 27);
        check("id_done_pulses", dc, 1);
        check("id_done_at", da, 27);
        check("id_err", int'(err), 0);
        expect_seq();
        burst_read_all();

        // Read+write L=3: old C shows, new A/B rows used by next OPERATE
        send(hdr(OP_BURST, BSEL_RDWR, 4'd3), 1'b0);
        exp_q.push_back(8'sd1); send({8'd2, 8'd10}, 1'b1);
        exp_q.push_back(8'sd2); send({8'd0, 8'd11}, 1'b1);
        exp_q.push_back(8'sd3); send({8'd0, 8'd12}, 1'b1);
        send(W_NOP, 1'b0);
        run_operate(-1, W_NOP, bc, dc, da);
        check("rw_done_pulses", dc, 1);
        exp_c[0] = 8'sd20; exp_c[1] = 8'sd22; exp_c[2] = 8'sd24;
        exp_c[3] = 8'sd4;  exp_c[4] = 8'sd5;  exp_c[5] = 8'sd6;
        exp_c[6] = 8'sd7;  exp_c[7] = 8'sd8;  exp_c[8] = 8'sd9;
        burst_read_all();

        // BURST header during COMPUTE: sticky error, results intact
        load_identity_b();
        burst_write_all();
        run_operate(5, hdr(OP_BURST, BSEL_WRITE, 4'd9), bc, dc, da);
        check("berr_busy_cycles", bc, 27);
        check("berr_done_pulses", dc, 1);
        check("berr_err", int'(err), 1);
        expect_seq();
        burst_read_all();
        check("berr_err_sticky", int'(err), 1);
        send(W_RESET, 1'b0);
        send(W_NOP, 1'b0);
        check("rst_op_clears_err", int'(err), 0);

        // RESET opcode during COMPUTE: abort, no done, C wiped
        load_identity_b();
        burst_write_all();
        send(hdr(OP_BURST, 2'b11, 4'd1), 1'b0);   // set error so the clear is observable
        send(W_NOP, 1'b0);
        check("pre_abort_err", int'(err), 1);
        run_operate(5, W_RESET, bc, dc, da);
        check("abort_busy_cycles", bc, 6);
        check("abort_done_pulses", dc, 0);
        check("abort_err", int'(err), 0);
        expect_zero();
        burst_read_all();

        // Saturation / wrap: all 127
        for (int e = 0; e < 9; e++) begin
            wa[e] = 8'd127;
            wb[e] = 8'd127;
        end
        burst_write_all();
        run_operate(-1, W_NOP, bc, dc, da);
        check("sat_done_pulses", dc, 1);
        for (int e = 0; e < 9; e++) begin
`ifdef TENSOR_CORE_SATURATE_EN
            exp_c[e] = 8'sd127;
`else
            exp_c[e] = 8'sd3;
`endif
        end
        burst_read_all();

        // Illegal headers: error set, stay IDLE, next word decoded as an opcode
        bad_hdr[0] = hdr(OP_BURST, BSEL_READ, 4'd0);
        bad_hdr[1] = hdr(OP_BURST, BSEL_READ, 4'd10);
        bad_hdr[2] = hdr(OP_BURST, BSEL_ILLEGAL, 4'd3);
        for (int h = 0; h < 3; h++) begin
            send(bad_hdr[h], 1'b0);
            send(W_OPERATE, 1'b0);
            send(W_NOP, 1'b0);
            check($sformatf("bad_hdr%0d_err", h), int'(err), 1);
            check($sformatf("bad_hdr%0d_next_decoded", h), int'(busy), 1);
            repeat (30) send(W_NOP, 1'b0);
            check($sformatf("bad_hdr%0d_idle", h), int'(busy), 0);
            send(W_RESET, 1'b0);
            send(W_NOP, 1'b0);
            check($sformatf("bad_hdr%0d_clr", h), int'(err), 0);
        end

        send(W_NOP, 1'b0);
        @(posedge clock_in);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
